// File: rtl/scratch_div_seq_ctrl.sv
// scratch_div_seq_ctrl: walks scratch memory for the divider stage.
// Per item: fetch operand pair, pulse rd_data_rdy, wait for div_done,
// write the quotient address strobe. Configurable bases, strides, read
// latency and run length.
// Optional build macro SCRATCH_DIV_PREFETCH_EN overlaps the next operand
// fetch with the current division.
module scratch_div_seq_ctrl #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SRC_BASE   = 64,
    parameter int unsigned SRC_STRIDE = 2,
    parameter int unsigned B_OFFSET   = 1,
    parameter int unsigned DST_BASE   = 128,
    parameter int unsigned DST_STRIDE = 1,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  len,
    input  logic              div_done,
    output logic [ADDR_W-1:0] sc_mem_rd_addr1,
    output logic [ADDR_W-1:0] sc_mem_rd_addr2,
    output logic              sc_mem_rd_data_rdy,
    output logic [ADDR_W-1:0] sc_mem_wt_addr,
    output logic              sc_mem_wt_en,
    output logic              busy,
    output logic              done
);

    // Latency counter only needs to reach RD_LAT (at most 15).
    localparam int unsigned LAT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RDY,
        S_WAIT_DIV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_nxt;
    logic [ADDR_W-1:0]  rd_addr1_nxt;
    logic [ADDR_W-1:0]  rd_addr2_nxt;
    logic [ADDR_W-1:0]  wt_addr_nxt;
    logic               rdy_nxt;
    logic               wt_en_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    logic [CNT_W-1:0]   idx_inc;
    logic               last_item;
    logic               lat_full;

    // Operand A address of item i, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] src_addr(input logic [CNT_W-1:0] i);
        return ADDR_W'(SRC_BASE) + ADDR_W'(ADDR_W'(i) * ADDR_W'(SRC_STRIDE));
    endfunction

    // Destination address of item i, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] dst_addr(input logic [CNT_W-1:0] i);
        return ADDR_W'(DST_BASE) + ADDR_W'(ADDR_W'(i) * ADDR_W'(DST_STRIDE));
    endfunction

    // Item bookkeeping shared by several states.
    always_comb begin
        idx_inc   = idx + CNT_W'(1);
        last_item = (idx_inc == len_q);
        lat_full  = (lat_cnt == LAT_W'(RD_LAT));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            idx                <= '0;
            len_q              <= '0;
            lat_cnt            <= '0;
            sc_mem_rd_addr1    <= '0;
            sc_mem_rd_addr2    <= '0;
            sc_mem_wt_addr     <= '0;
            sc_mem_rd_data_rdy <= 1'b0;
            sc_mem_wt_en       <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            state              <= state_nxt;
            idx                <= idx_nxt;
            len_q              <= len_nxt;
            lat_cnt            <= lat_nxt;
            sc_mem_rd_addr1    <= rd_addr1_nxt;
            sc_mem_rd_addr2    <= rd_addr2_nxt;
            sc_mem_wt_addr     <= wt_addr_nxt;
            sc_mem_rd_data_rdy <= rdy_nxt;
            sc_mem_wt_en       <= wt_en_nxt;
            busy               <= busy_nxt;
            done               <= done_nxt;
        end
    end

    // Next-state logic; lat_cnt counts cycles since the last read issue,
    // saturating at RD_LAT, and is zeroed on the cycle the addresses appear.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        len_nxt      = len_q;
        lat_nxt      = lat_full ? lat_cnt : lat_cnt + LAT_W'(1);
        rd_addr1_nxt = sc_mem_rd_addr1;
        rd_addr2_nxt = sc_mem_rd_addr2;
        wt_addr_nxt  = sc_mem_wt_addr;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    len_nxt = len;
                    idx_nxt = '0;
                    if (len == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_ISSUE;
                        rd_addr1_nxt = src_addr('0);
                        rd_addr2_nxt = src_addr('0) + ADDR_W'(B_OFFSET);
                        lat_nxt      = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (lat_full) begin
                    state_nxt = S_RDY;
                end
            end
            S_RDY: begin
                state_nxt = S_WAIT_DIV;
`ifdef SCRATCH_DIV_PREFETCH_EN
                if (!last_item) begin
                    rd_addr1_nxt = src_addr(idx_inc);
                    rd_addr2_nxt = src_addr(idx_inc) + ADDR_W'(B_OFFSET);
                    lat_nxt      = '0;
                end
`endif
            end
            S_WAIT_DIV: begin
                if (div_done) begin
                    state_nxt   = S_WRITE;
                    wt_addr_nxt = dst_addr(idx);
                end
            end
            S_WRITE: begin
                idx_nxt = idx_inc;
                if (last_item) begin
                    state_nxt = S_DONE;
                end else begin
`ifdef SCRATCH_DIV_PREFETCH_EN
                    state_nxt = lat_full ? S_RDY : S_WAIT_RD;
`else
                    state_nxt    = S_ISSUE;
                    rd_addr1_nxt = src_addr(idx_inc);
                    rd_addr2_nxt = src_addr(idx_inc) + ADDR_W'(B_OFFSET);
                    lat_nxt      = '0;
`endif
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        rdy_nxt   = (state_nxt == S_RDY);
        wt_en_nxt = (state_nxt == S_WRITE);
        done_nxt  = (state_nxt == S_DONE);
        busy_nxt  = (state_nxt != S_IDLE);
    end

endmodule

// File: doc/scratch_div_seq_ctrl.md
Name: scratch_div_seq_ctrl

Overview:
Parametrised sequencer that walks scratch memory for the divider stage. For each item it fetches an operand pair, signals the divider that the data is ready, waits for div_done, and issues one write of the quotient to the destination region. It replaces the fixed 64-entry divider memory controller. Base addresses, strides, read latency and run length are all configurable, with an optional read-prefetch overlap mode.

Parameters:
ADDR_W, 16, scratch address width
CNT_W, 8, item counter and len width
SRC_BASE, 64, address of operand A for item 0
SRC_STRIDE, 2, address increment between items on the read side
B_OFFSET, 1, operand B address = operand A address + B_OFFSET
DST_BASE, 128, write address for item 0
DST_STRIDE, 1, address increment between items on the write side
RD_LAT, 2, scratch read latency in cycles (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  start pulse; sampled only in IDLE
len  in  CNT_W  item count; latched when a start is accepted
div_done  in  1  divider finished the current item; sampled only in WAIT_DIV
sc_mem_rd_addr1  out  ADDR_W  operand A read address
sc_mem_rd_addr2  out  ADDR_W  operand B read address
sc_mem_rd_data_rdy  out  1  one-cycle pulse: operand pair valid for the divider
sc_mem_wt_addr  out  ADDR_W  write address
sc_mem_wt_en  out  1  one-cycle write strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run ends

Behaviour:
- All outputs are registered.
- Reset values: all addresses 0; rd_data_rdy, wt_en, busy and done all 0; state IDLE; idx 0. Reset mid-run aborts immediately with no further strobes.
- States: IDLE, ISSUE, WAIT_RD, RDY, WAIT_DIV, WRITE, DONE.
- IDLE:
  - enable=1: latch len and clear idx.
  - If len==0, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: present rd_addr1 = SRC_BASE + idx*SRC_STRIDE and rd_addr2 = rd_addr1 + B_OFFSET. Go to WAIT_RD.
- WAIT_RD: stay for RD_LAT cycles, then go to RDY.
  - Result: rd_data_rdy is high exactly RD_LAT+1 cycles after the addresses first appear.
- RDY: rd_data_rdy=1 for one cycle. Go to WAIT_DIV.
- WAIT_DIV: hold until div_done=1, then go to WRITE.
- WRITE: wt_en=1 for one cycle with wt_addr = DST_BASE + idx*DST_STRIDE. Increment idx.
  - If the new idx == latched len, go to DONE.
  - Otherwise go to ISSUE.
- DONE: done=1 for one cycle. Go to IDLE.
- Read and write addresses hold their last values between strobes.
- Arithmetic: all address math is modulo 2^ADDR_W, so wrap-around is silent. idx is CNT_W bits wide, so len=2^CNT_W-1 is the maximum run.
- Ignored events:
  - enable while busy is ignored; len is not re-latched.
  - div_done outside WAIT_DIV is ignored and is not remembered.
  - enable and div_done in the same IDLE cycle: start only.

Optional Feature:
Macro: SCRATCH_DIV_PREFETCH_EN
- Defined: the controller overlaps the next fetch with the current division.
  - One cycle after the RDY pulse for item i, with i+1<len, it presents item i+1's read addresses.
  - A latency counter tracks the outstanding read.
  - On WRITE of item i, the controller goes straight to RDY for item i+1 if RD_LAT cycles have elapsed since that issue. Otherwise it goes to WAIT_RD for the remaining cycles.
  - Minimum spacing is therefore wt_en for item i followed one cycle later by rd_data_rdy for item i+1.
  - rd_data_rdy never asserts before the write of the previous item.
- Undefined: strictly sequential operation as described in Behaviour.

Test Plan:
- Defaults, len=3, div_done two cycles after each RDY pulse:
  - Read pairs (64,65), (66,67), (68,69); writes to 128, 129, 130.
  - rd_data_rdy three cycles after each address change.
  - done one cycle after the third wt_en.
- len=0 with enable pulse -> done one cycle after leaving IDLE; no rd_data_rdy and no wt_en; busy high for exactly one cycle.
- div_done held high through RDY, plus a stray div_done pulse in IDLE:
  - The IDLE pulse is ignored.
  - Each item produces exactly one wt_en.
  - WRITE occurs on the first WAIT_DIV cycle.
- enable re-pulsed mid-run with a different len=5, first run len=2 -> exactly 2 writes; the second enable has no effect.
- reset asserted in WAIT_DIV of item 1, then enable with len=1:
  - All outputs read 0 one cycle after reset.
  - The new run restarts at read addresses 64/65 and write address 128.
- SCRATCH_DIV_PREFETCH_EN defined, RD_LAT=2, len=2, div_done four cycles after RDY:
  - Addresses 66/67 appear one cycle after the first RDY pulse.
  - The second rd_data_rdy asserts the cycle after the first wt_en.
